// File: rtl/bbox_extract.sv
// rtl/bbox_extract.sv - per-frame foreground bounding-box extractor for the overlay stage
// Optional feature: define BBOX_MARGIN_EN to expand each valid box by MARGIN, clamped to the image.
module bbox_extract #(
    parameter logic [10:0] IMG_HDISP  = 11'd1024,
    parameter logic [10:0] IMG_VDISP  = 11'd768,
    parameter logic [19:0] MIN_PIXELS = 20'd64,
    parameter logic [10:0] MARGIN     = 11'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    output logic [10:0] rectangular_up,
    output logic [10:0] rectangular_down,
    output logic [10:0] rectangular_left,
    output logic [10:0] rectangular_right,
    output logic        flag,
    output logic        frame_done
);

    logic        vsync_d;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [10:0] min_x;
    logic [10:0] max_x;
    logic [10:0] min_y;
    logic [10:0] max_y;
    logic [19:0] pix_cnt;

    logic        frame_end;
    logic        fg_pix;
    logic        box_valid;
    logic [10:0] load_up;
    logic [10:0] load_down;
    logic [10:0] load_left;
    logic [10:0] load_right;

    // href carries no extra information here; pixel position comes from clken alone
    logic        href_unused;
    assign href_unused = per_frame_href;

    assign frame_end = per_frame_vsync && !vsync_d;
    assign fg_pix    = per_frame_clken && !per_frame_vsync && per_img_bit && (y_cnt < IMG_VDISP);
    assign box_valid = (pix_cnt >= MIN_PIXELS);

`ifdef BBOX_MARGIN_EN
    logic [11:0] down_sum;
    logic [11:0] right_sum;
    logic [11:0] down_lim;
    logic [11:0] right_lim;

    // sums are 12 bits wide so the clamp comparison sees any carry out of 11 bits
    always_comb begin
        down_sum   = {1'b0, max_y} + {1'b0, MARGIN};
        right_sum  = {1'b0, max_x} + {1'b0, MARGIN};
        down_lim   = {1'b0, IMG_VDISP} - 12'd1;
        right_lim  = {1'b0, IMG_HDISP} - 12'd1;
        load_up    = (min_y > MARGIN) ? (min_y - MARGIN) : 11'd0;
        load_left  = (min_x > MARGIN) ? (min_x - MARGIN) : 11'd0;
        load_down  = (down_sum > down_lim) ? down_lim[10:0] : down_sum[10:0];
        load_right = (right_sum > right_lim) ? right_lim[10:0] : right_sum[10:0];
    end
`else
    always_comb begin
        load_up    = min_y;
        load_down  = max_y;
        load_left  = min_x;
        load_right = max_x;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            x_cnt   <= 11'd0;
            y_cnt   <= 11'd0;
        end else begin
            vsync_d <= per_frame_vsync;
            if (per_frame_vsync) begin
                x_cnt <= 11'd0;
                y_cnt <= 11'd0;
            end else if (per_frame_clken) begin
                if (x_cnt == IMG_HDISP - 11'd1) begin
                    x_cnt <= 11'd0;
                    if (y_cnt != 11'h7FF) begin
                        y_cnt <= y_cnt + 11'd1;
                    end
                end else begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x   <= 11'h7FF;
            max_x   <= 11'd0;
            min_y   <= 11'h7FF;
            max_y   <= 11'd0;
            pix_cnt <= 20'd0;
        end else if (frame_end) begin
            min_x   <= 11'h7FF;
            max_x   <= 11'd0;
            min_y   <= 11'h7FF;
            max_y   <= 11'd0;
            pix_cnt <= 20'd0;
        end else if (fg_pix) begin
            if (x_cnt < min_x) min_x <= x_cnt;
            if (x_cnt > max_x) max_x <= x_cnt;
            if (y_cnt < min_y) min_y <= y_cnt;
            if (y_cnt > max_y) max_y <= y_cnt;
            if (pix_cnt != 20'hFFFFF) pix_cnt <= pix_cnt + 20'd1;
        end
    end

    // a frame below MIN_PIXELS keeps the previous box so the overlay never sees noise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rectangular_up    <= 11'd0;
            rectangular_down  <= 11'd0;
            rectangular_left  <= 11'd0;
            rectangular_right <= 11'd0;
            flag              <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                flag <= box_valid;
                if (box_valid) begin
                    rectangular_up    <= load_up;
                    rectangular_down  <= load_down;
                    rectangular_left  <= load_left;
                    rectangular_right <= load_right;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_extract.sv
// tb/tb_bbox_extract.sv - scoreboard bench for bbox_extract on a 16x8 image
module tb_bbox_extract;

    logic        clk;
    logic        rst;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic        per_img_bit;
    logic [10:0] rectangular_up;
    logic [10:0] rectangular_down;
    logic [10:0] rectangular_left;
    logic [10:0] rectangular_right;
    logic        flag;
    logic        frame_done;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int done_seen = 0;
    logic prev_done = 1'b0;
    logic [44:0] exp_q[$];

    bbox_extract #(
        .IMG_HDISP (11'd16),
        .IMG_VDISP (11'd8),
        .MIN_PIXELS(20'd4),
        .MARGIN    (11'd2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_bit      (per_img_bit),
        .rectangular_up   (rectangular_up),
        .rectangular_down (rectangular_down),
        .rectangular_left (rectangular_left),
        .rectangular_right(rectangular_right),
        .flag             (flag),
        .frame_done       (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [44:0] got, input logic [44:0] expv);
        total_cnt++;
        if (got === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            logic [44:0] e;
            done_seen++;
            check("frame_done_single_cycle", {44'd0, prev_done}, 45'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 45'd1, 45'd0);
            end else begin
                e = exp_q.pop_front();
                check("box_up_down_left_right_flag",
                      {rectangular_up, rectangular_down, rectangular_left, rectangular_right, flag}, e);
            end
        end
        prev_done = frame_done;
    end

    task automatic step(input logic v, input logic c, input logic b);
        per_frame_vsync = v;
        per_frame_clken = c;
        per_frame_href  = c & ~v;
        per_img_bit     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [127:0] m);
        for (int i = 0; i < 128; i++) step(1'b0, 1'b1, m[i]);
    endtask

    // blanking also carries clken with bit=1, which must never be counted
    task automatic end_frame(input logic [10:0] u, input logic [10:0] d,
                             input logic [10:0] l, input logic [10:0] r, input logic f);
        exp_q.push_back({u, d, l, r, f});
        step(1'b1, 1'b0, 1'b0);
        check("frame_done_latency", {44'd0, frame_done}, 45'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        check("frame_done_cleared", {44'd0, frame_done}, 45'd0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [127:0] px(input logic [127:0] m, input int x, input int y);
        logic [127:0] r;
        r = m;
        r[y*16 + x] = 1'b1;
        return r;
    endfunction

    initial begin
        logic [127:0] m;
        rst = 1'b1;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_bit     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_up",    {34'd0, rectangular_up},    45'd0);
        check("reset_down",  {34'd0, rectangular_down},  45'd0);
        check("reset_left",  {34'd0, rectangular_left},  45'd0);
        check("reset_right", {34'd0, rectangular_right}, 45'd0);
        check("reset_flag",  {44'd0, flag},              45'd0);
        check("reset_done",  {44'd0, frame_done},        45'd0);
        rst = 1'b0;

        m = '0;
        for (int y = 2; y <= 4; y++)
            for (int x = 5; x <= 9; x++) m = px(m, x, y);
        send_frame(m);
`ifdef BBOX_MARGIN_EN
        end_frame(11'd0, 11'd6, 11'd3, 11'd11, 1'b1);
`else
        end_frame(11'd2, 11'd4, 11'd5, 11'd9, 1'b1);
`endif

        m = '0;
        m = px(m, 1, 1);
        m = px(m, 2, 1);
        m = px(m, 3, 1);
        send_frame(m);
`ifdef BBOX_MARGIN_EN
        end_frame(11'd0, 11'd6, 11'd3, 11'd11, 1'b0);
`else
        end_frame(11'd2, 11'd4, 11'd5, 11'd9, 1'b0);
`endif

        m = '0;
        m = px(m, 0, 0);
        m = px(m, 15, 7);
        m = px(m, 3, 3);
        m = px(m, 4, 4);
        send_frame(m);
        end_frame(11'd0, 11'd7, 11'd0, 11'd15, 1'b1);

        send_frame(128'd0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1);
        end_frame(11'd0, 11'd7, 11'd0, 11'd15, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_up",    {34'd0, rectangular_up},    45'd0);
        check("midrst_down",  {34'd0, rectangular_down},  45'd0);
        check("midrst_left",  {34'd0, rectangular_left},  45'd0);
        check("midrst_right", {34'd0, rectangular_right}, 45'd0);
        check("midrst_flag",  {44'd0, flag},              45'd0);
        check("midrst_done",  {44'd0, frame_done},        45'd0);
        per_frame_clken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        end_frame(11'd0, 11'd0, 11'd0, 11'd0, 1'b0);

        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("frame_done_count", 45'(done_seen), 45'd5);
        check("scoreboard_drained", 45'(exp_q.size()), 45'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bbox_extract.md
# bbox_extract

Per-frame bounding-box extractor for the human-detection path. Consumes a binary foreground mask stream using the same vsync/href/clken pixel protocol as the overlay stage. Tracks min/max column and row of foreground pixels over one frame and, at the next frame start, publishes `rectangular_up/down/left/right` plus `flag` in exactly the form the rectangle-overlay stage consumes. Sits between the binarisation/morphology stage and the overlay stage.

## Interface
- `IMG_HDISP`, 11'd1024, active pixels per line; column counter wraps here.
- `IMG_VDISP`, 11'd768, active lines per frame; rows >= this are ignored.
- `MIN_PIXELS`, 20'd64, minimum foreground count for a valid box; must be >= 1.
- `MARGIN`, 11'd2, box expansion in pixels; used only when `BBOX_MARGIN_EN` is defined.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `per_frame_vsync`  in  1  high during vertical blanking; rising edge marks frame boundary.
- `per_frame_href`  in  1  line valid; informational only, not used for counting.
- `per_frame_clken`  in  1  one pixel valid this cycle.
- `per_img_bit`  in  1  mask pixel, 1 = foreground.
- `rectangular_up`  out  11  top row of last valid box.
- `rectangular_down`  out  11  bottom row of last valid box.
- `rectangular_left`  out  11  left column of last valid box.
- `rectangular_right`  out  11  right column of last valid box.
- `flag`  out  1  last completed frame produced a valid box.
- `frame_done`  out  1  one-cycle pulse when outputs are updated.

## Operation
- Reset: all four coordinates 0, `flag` 0, `frame_done` 0, `x_cnt`/`y_cnt` 0, `vsync_d` 0, accumulators at empty state.
- Empty state: `min_x`=`min_y`=11'h7FF, `max_x`=`max_y`=0, `pix_cnt`=0.
- Pixel counters: while `per_frame_vsync`=1 both are held at 0. Otherwise, on `per_frame_clken`, `x_cnt` increments; at `IMG_HDISP-1` it wraps to 0 and `y_cnt` increments (`y_cnt` saturates at 11'h7FF).
- Accumulate: when `per_frame_clken`=1, `per_frame_vsync`=0, `per_img_bit`=1, `y_cnt < IMG_VDISP`: update `min_x`/`max_x` with `x_cnt`, `min_y`/`max_y` with `y_cnt`; increment `pix_cnt`, saturating at 20'hFFFFF.
- Frame end: event E = `per_frame_vsync`=1 and `vsync_d`=0 (`vsync_d` is the registered `per_frame_vsync`). On E:
  - If `pix_cnt >= MIN_PIXELS`: load coordinates (up=`min_y`, down=`max_y`, left=`min_x`, right=`max_x`), `flag`=1.
  - Else: coordinates hold previous values, `flag`=0.
  - `frame_done`=1 for that cycle only. Accumulators return to the empty state in the same edge.
- Any pixel arriving on the E cycle is discarded, because vsync is high.
- The first E after reset reports whatever was accumulated since reset. A partial frame yields a valid box only if it meets `MIN_PIXELS`.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is lost.

## Timing
- Coordinates, `flag` and `frame_done` are registered and change only at the clock edge that samples E. They are visible one edge after vsync first rises, and stable for the whole following frame.
- Pixel-to-accumulator latency: one cycle. A foreground pixel on the last clken before vsync rises is included.
- No backpressure; an input pixel is accepted every cycle `per_frame_clken`=1.

## Configuration
- `BBOX_MARGIN_EN` defined: on a valid load, the box expands by `MARGIN` and is clamped to the image.
  - up = `min_y` > `MARGIN` ? `min_y`-`MARGIN` : 0
  - down = min(`max_y`+`MARGIN`, `IMG_VDISP`-1)
  - left = `min_x` > `MARGIN` ? `min_x`-`MARGIN` : 0
  - right = min(`max_x`+`MARGIN`, `IMG_HDISP`-1)
  - Compute in 12 bits; no wrap-around.
- `BBOX_MARGIN_EN` undefined: raw min/max loaded; `MARGIN` is unused.

## Test plan
- Common setup: IMG_HDISP=16, IMG_VDISP=8, MIN_PIXELS=4, MARGIN=2.
- Foreground block x 5..9, y 2..4 (15 pixels), then vsync -> one-cycle `frame_done`, up=2, down=4, left=5, right=9, flag=1; same with macro: up=0, down=6, left=3, right=11.
- Frame with 3 foreground pixels after the valid frame above -> flag=0, coordinates still 2/4/5/9, `frame_done` pulses.
- Foreground at (0,0) and (15,7) plus 2 more anywhere, with macro -> up=0, left=0, down=7, right=15; no underflow or overflow.
- clken with bit=1 while vsync=1, and rows y>=8 (extra clken past the frame) -> not counted; an empty frame gives flag=0.
- Assert `rst` mid-frame after 10 foreground pixels, release, send 2 more, then vsync -> all outputs reset to 0 immediately; the subsequent E gives flag=0.
